// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, destination formats, flag positions
// and exponent biases.
package fpu_pkg;

   typedef enum logic [2:0] {
      RM_RNE = 3'b000,
      RM_RTZ = 3'b001,
      RM_RDN = 3'b010,
      RM_RUP = 3'b011,
      RM_RMM = 3'b100
   } round_mode_e;

   typedef enum logic {
      FMT_S = 1'b0,
      FMT_D = 1'b1
   } dst_fmt_e;

   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   localparam logic [7:0]  BIAS_S = 8'd127;
   localparam logic [10:0] BIAS_D = 11'd1023;

endpackage

// File: rtl/fpu_round_incr.sv
// Round-increment decision from the rounding mode, sign and the lsb/guard/sticky
// bits of the truncated significand.
module fpu_round_incr
   import fpu_pkg::*;
(
   input  logic [2:0] rm,
   input  logic       sign,
   input  logic       lsb,
   input  logic       guard,
   input  logic       sticky,
   output logic       incr
);

   // Reserved encodings fall through to round-to-nearest-even.
   always_comb begin
      incr = guard & (sticky | lsb);
      case (round_mode_e'(rm))
         RM_RTZ:  incr = 1'b0;
         RM_RDN:  incr = sign & (guard | sticky);
         RM_RUP:  incr = ~sign & (guard | sticky);
         RM_RMM:  incr = guard;
         default: incr = guard & (sticky | lsb);
      endcase
   end

endmodule

// File: rtl/fpu_int2fp_round.sv
// Integer-to-float back end: S1 normalises the magnitude and forms the exponent,
// S2 rounds to binary32/binary64 and packs the result behind a valid/ready output.
module fpu_int2fp_round
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_mag,
   input  logic        in_sign,
   input  logic [6:0]  in_lzc,
   input  logic        in_dst_fmt,
   input  logic [2:0]  in_rm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [4:0]  out_flags
);

   logic        s1_valid_q, s1_valid_d;
   logic [63:0] s1_mant_q, s1_mant_d;
   logic [5:0]  s1_exp_q, s1_exp_d;
   logic        s1_sign_q, s1_sign_d;
   logic        s1_zero_q, s1_zero_d;
   logic        s1_fmt_q, s1_fmt_d;
   logic [2:0]  s1_rm_q, s1_rm_d;

   logic        s2_valid_q, s2_valid_d;
   logic [63:0] s2_result_q, s2_result_d;
   logic [4:0]  s2_flags_q, s2_flags_d;

   logic        s2_adv;
   logic        lsb, guard, sticky, incr;
   logic        carry_s, carry_d;
   logic [22:0] frac_s;
   logic [51:0] frac_d;
   logic [7:0]  exp_s;
   logic [10:0] exp_d;

   assign s2_adv     = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || s2_adv;
   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_flags  = s2_flags_q;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_mant_d  = s1_mant_q;
      s1_exp_d   = s1_exp_q;
      s1_sign_d  = s1_sign_q;
      s1_zero_d  = s1_zero_q;
      s1_fmt_d   = s1_fmt_q;
      s1_rm_d    = s1_rm_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_mant_d = in_mag << in_lzc[5:0];
            s1_exp_d  = 6'd63 - in_lzc[5:0];
            s1_sign_d = in_sign;
            s1_zero_d = in_lzc[6];
            s1_fmt_d  = in_dst_fmt;
            s1_rm_d   = in_rm;
         end
      end
   end

   always_comb begin
      if (s1_fmt_q == FMT_D) begin
         lsb    = s1_mant_q[11];
         guard  = s1_mant_q[10];
         sticky = |s1_mant_q[9:0];
      end else begin
         lsb    = s1_mant_q[40];
         guard  = s1_mant_q[39];
         sticky = |s1_mant_q[38:0];
      end
   end

   fpu_round_incr u_round_incr (
      .rm     (s1_rm_q),
      .sign   (s1_sign_q),
      .lsb    (lsb),
      .guard  (guard),
      .sticky (sticky),
      .incr   (incr)
   );

   // An all-ones significand that rounds up wraps the fraction to zero and bumps the exponent.
   assign carry_s = incr & (&s1_mant_q[63:40]);
   assign carry_d = incr & (&s1_mant_q[63:11]);
   assign frac_s  = s1_mant_q[62:40] + {22'd0, incr};
   assign frac_d  = s1_mant_q[62:11] + {51'd0, incr};
   assign exp_s   = {2'b00, s1_exp_q} + BIAS_S + {7'd0, carry_s};
   assign exp_d   = {5'd0, s1_exp_q} + BIAS_D + {10'd0, carry_d};

   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_flags_d  = s2_flags_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_flags_d[FLAG_NV] = 1'b0;
            s2_flags_d[FLAG_DZ] = 1'b0;
            s2_flags_d[FLAG_OF] = 1'b0;
            s2_flags_d[FLAG_UF] = 1'b0;
            s2_flags_d[FLAG_NX] = 1'b0;
            if (s1_zero_q) begin
               s2_result_d = (s1_fmt_q == FMT_D) ? 64'd0 : {32'hFFFF_FFFF, 32'd0};
            end else begin
               s2_flags_d[FLAG_NX] = guard | sticky;
               if (s1_fmt_q == FMT_D) begin
                  s2_result_d = {s1_sign_q, exp_d, frac_d};
               end else begin
                  s2_result_d = {32'hFFFF_FFFF, s1_sign_q, exp_s, frac_s};
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_mant_q   <= '0;
         s1_exp_q    <= '0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_fmt_q    <= 1'b0;
         s1_rm_q     <= '0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_flags_q  <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_mant_q   <= s1_mant_d;
         s1_exp_q    <= s1_exp_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_fmt_q    <= s1_fmt_d;
         s1_rm_q     <= s1_rm_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_flags_q  <= s2_flags_d;
      end
   end

endmodule
